// File: rtl/axi_fft_ctrl.sv
// axi_fft_ctrl: AXI4-Lite control/status slave for the FFT core.
//
// Holds the register file, issues start/inverse/channel commands to the core,
// tracks completion through an IDLE/RUN state machine, counts finished frames
// and drives a maskable level interrupt. Single clock domain (s_axi_aclk).
//
// Optional build macro: AXI_FFT_TIMEOUT_EN enables a RUN watchdog that aborts
// after TIMEOUT_CYCLES cycles without fft_done and sets STATUS.TIMEOUT.
//
// Ports:
//   s_axi_aclk / s_axi_aresetn   clock, async active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b*  AXI4-Lite write channels (prot ignored)
//   s_axi_ar* / s_axi_r*             AXI4-Lite read channels (prot ignored)
//   fft_start    one-cycle command pulse to the core
//   fft_inverse  inverse-transform select, valid with fft_start
//   fft_ch       channel select, valid with fft_start
//   fft_done     one-cycle completion pulse from the core
//   irq          level interrupt
//
// Register map (byte offsets, decoded on addr[6:2]):
//   0x00 VERSION   0x04 SCRATCH   0x08 CONFIG   0x0C CONTROL
//   0x10 STATUS    0x14 IRQ_MASK  0x18 FRAME_CNT
module axi_fft_ctrl #(
   parameter int NFFT           = 8,
   parameter int NUM_CH         = 2,
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [2:0]            s_axi_awprot,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic [1:0]            s_axi_bresp,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [2:0]            s_axi_arprot,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  fft_start,
   output logic                  fft_inverse,
   output logic [7:0]            fft_ch,
   input  logic                  fft_done,
   output logic                  irq
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [7:0]  NFFT_B   = 8'(NFFT);
   localparam logic [7:0]  NUM_CH_B = 8'(NUM_CH);
   localparam logic [31:0] VERSION  = 32'h0002_0000;
   localparam logic [4:0]  A_VER = 5'd0, A_SCR = 5'd1, A_CFG = 5'd2, A_CTL = 5'd3,
                           A_STS = 5'd4, A_MSK = 5'd5, A_FRM = 5'd6;

   state_t      state_q, state_d;
   logic        bvalid_q, rvalid_q;
   logic [31:0] rdata_q, rd_val;
   logic [31:0] scratch_q, frame_q;
   logic        inv_q;
   logic [7:0]  ch_q;
   logic [1:0]  mask_q;
   logic        done_q, err_q, tmo_q;
   logic        start_q, finv_q;
   logic [7:0]  fch_q;
   logic        irq_q;

   logic        wr_en, rd_en, wr_ctl, wr_sts, busy;
   logic        start_req, start_ok, start_err, done_hit, tmo_hit;
   logic [4:0]  wa, ra;
   logic [7:0]  ch_new;
   logic        inv_new;

   // prot and the undecoded address bits carry no meaning here
   logic unused_bits;
   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

   // Address and data are accepted together in one beat; a held response blocks the next.
   assign wr_en = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
   assign rd_en = s_axi_arvalid & ~rvalid_q;
   assign wa    = s_axi_awaddr[6:2];
   assign ra    = s_axi_araddr[6:2];
   assign wr_ctl = wr_en && (wa == A_CTL);
   assign wr_sts = wr_en && (wa == A_STS) && s_axi_wstrb[0];
   assign busy   = (state_q == RUN);

   // A START beat uses the CH_SEL/INVERSE values written in that same beat.
   assign ch_new    = (wr_ctl && s_axi_wstrb[1]) ? s_axi_wdata[15:8] : ch_q;
   assign inv_new   = (wr_ctl && s_axi_wstrb[0]) ? s_axi_wdata[1]    : inv_q;
   assign start_req = wr_ctl & s_axi_wstrb[0] & s_axi_wdata[0];
   assign start_ok  = start_req && !busy && (ch_new < NUM_CH_B);
   assign start_err = start_req & ~start_ok;
   assign done_hit  = busy & fft_done;

`ifdef AXI_FFT_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] tcnt_q;
   // done on the expiry cycle takes priority over the timeout
   assign tmo_hit = busy && !fft_done && (tcnt_q == TMO_LAST);

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         tcnt_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         if (start_ok)  tcnt_q <= '0;
         else if (busy) tcnt_q <= tcnt_q + 32'd1;
         tmo_q <= tmo_hit | (tmo_q & ~(wr_sts & s_axi_wdata[3]));
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign tmo_q   = 1'b0;
`endif

   // FSM
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) state_q <= IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_ok)             state_d = RUN;
         RUN:  if (done_hit || tmo_hit)  state_d = IDLE;
      endcase
   end

   // Read mux, sampled into rdata on the address handshake
   always_comb begin
      rd_val = '0;
      case (ra)
         A_VER: rd_val = VERSION;
         A_SCR: rd_val = scratch_q;
         A_CFG: rd_val = {16'd0, NUM_CH_B, NFFT_B};
         A_CTL: rd_val = {16'd0, ch_q, 6'd0, inv_q, 1'b0};
         A_STS: rd_val = {28'd0, tmo_q, err_q, done_q, busy};
         A_MSK: rd_val = {30'd0, mask_q};
         A_FRM: rd_val = frame_q;
         default: rd_val = '0;
      endcase
   end

   // AXI response side
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (wr_en)             bvalid_q <= 1'b1;
         else if (s_axi_bready) bvalid_q <= 1'b0;
         if (rd_en) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
         end else if (s_axi_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   // Register file, flags, command outputs
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         scratch_q <= '0;
         inv_q     <= 1'b0;
         ch_q      <= '0;
         mask_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         frame_q   <= '0;
         start_q   <= 1'b0;
         finv_q    <= 1'b0;
         fch_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         if (wr_en && wa == A_SCR)
            for (int b = 0; b < 4; b++)
               if (s_axi_wstrb[b]) scratch_q[8*b +: 8] <= s_axi_wdata[8*b +: 8];
         inv_q <= inv_new;
         ch_q  <= ch_new;
         if (wr_en && wa == A_MSK && s_axi_wstrb[0]) mask_q <= s_axi_wdata[1:0];
         // hardware sets override a same-cycle W1C
         done_q <= done_hit  | (done_q & ~(wr_sts & s_axi_wdata[1]));
         err_q  <= start_err | (err_q  & ~(wr_sts & s_axi_wdata[2]));
         // clear and increment together leave the count at 1
         frame_q <= ((wr_en && wa == A_FRM) ? 32'd0 : frame_q) + 32'(done_hit);
         start_q <= start_ok;
         if (start_ok) begin
            finv_q <= inv_new;
            fch_q  <= ch_new;
         end
         irq_q <= (done_q & mask_q[0]) | ((err_q | tmo_q) & mask_q[1]);
      end
   end

   // Ready is combinational; gated so it stays low while reset is held.
   assign s_axi_awready = wr_en & s_axi_aresetn;
   assign s_axi_wready  = wr_en & s_axi_aresetn;
   assign s_axi_arready = rd_en & s_axi_aresetn;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = 2'b00;
   assign fft_start     = start_q;
   assign fft_inverse   = finv_q;
   assign fft_ch        = fch_q;
   assign irq           = irq_q;

endmodule
